// File: rtl/rx_frame_parse_pkg.sv
// Shared types and constants for the host-to-radio frame parser.
package rx_frame_parse_pkg;

    // Parser states: three sync bytes, five control bytes, then sample groups.
    typedef enum logic [2:0] {
        SYNC0   = 3'd0,
        SYNC1   = 3'd1,
        SYNC2   = 3'd2,
        CTRL    = 3'd3,
        SAMPLES = 3'd4
    } state_e;

    localparam int FRAME_BYTES = 512;
    localparam int CTRL_BYTES  = 5;
    localparam int GROUP_BYTES = 8;

    localparam logic [7:0] DEFAULT_SYNC_BYTE         = 8'h7F;
    localparam int         DEFAULT_SAMPLES_PER_FRAME = 63;

endpackage

// File: rtl/rx_frame_parse.sv
// Host-to-radio frame parser: locks to the 3-byte sync, captures C0..C4 as a
// command, and assembles the L/R/I/Q sample groups of each 512-byte frame.
// Handshake: a byte is consumed on every cycle with rx_fifo_enable=1; there is
// no back-pressure. Output pulses (cmd_valid, sample_valid, sync_err,
// frame_err) are single-cycle and appear one cycle after the causing byte.
module rx_frame_parse
    import rx_frame_parse_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE         = DEFAULT_SYNC_BYTE,
    parameter int         SAMPLES_PER_FRAME = DEFAULT_SAMPLES_PER_FRAME
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [7:0]  rx_fifo_data,
    input  logic        rx_fifo_enable,
    output logic        cmd_valid,
    output logic [6:0]  cmd_addr,
    output logic        cmd_ptt,
    output logic [31:0] cmd_data,
    output logic        sample_valid,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic [15:0] tx_i,
    output logic [15:0] tx_q,
    output logic        sync_err,
    output logic        frame_err
);

    state_e      state_q, state_d;
    logic [2:0]  ctrl_cnt_q, ctrl_cnt_d;
    logic [2:0]  grp_byte_q, grp_byte_d;
    logic [7:0]  grp_cnt_q, grp_cnt_d;
    logic [31:0] ctrl_sr_q, ctrl_sr_d;
    logic [55:0] smp_sr_q, smp_sr_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic [6:0]  cmd_addr_q, cmd_addr_d;
    logic        cmd_ptt_q, cmd_ptt_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic        sample_valid_q, sample_valid_d;
    logic [15:0] audio_l_q, audio_l_d;
    logic [15:0] audio_r_q, audio_r_d;
    logic [15:0] tx_i_q, tx_i_d;
    logic [15:0] tx_q_q, tx_q_d;
    logic        sync_err_q, sync_err_d;
    logic        frame_err_q, frame_err_d;

    // Full 40-bit command word and 64-bit group, completed by the current byte.
    logic [39:0] ctrl_full;
    logic [63:0] smp_full;

    // Append the incoming byte to the partially shifted words.
    always_comb begin
        ctrl_full = {ctrl_sr_q, rx_fifo_data};
        smp_full  = {smp_sr_q, rx_fifo_data};
    end

    // Next-state, counters, shift registers and registered outputs.
    always_comb begin
        state_d        = state_q;
        ctrl_cnt_d     = ctrl_cnt_q;
        grp_byte_d     = grp_byte_q;
        grp_cnt_d      = grp_cnt_q;
        ctrl_sr_d      = ctrl_sr_q;
        smp_sr_d       = smp_sr_q;
        cmd_valid_d    = 1'b0;
        cmd_addr_d     = cmd_addr_q;
        cmd_ptt_d      = cmd_ptt_q;
        cmd_data_d     = cmd_data_q;
        sample_valid_d = 1'b0;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;
        tx_i_d         = tx_i_q;
        tx_q_d         = tx_q_q;
        sync_err_d     = 1'b0;
        frame_err_d    = 1'b0;

        case (state_q)
            SYNC0: begin
                // Hunting: non-sync bytes and idle cycles are dropped quietly.
                if (rx_fifo_enable && rx_fifo_data == SYNC_BYTE) state_d = SYNC1;
            end
            SYNC1, SYNC2: begin
                if (!rx_fifo_enable) begin
                    frame_err_d = 1'b1;
                    state_d     = SYNC0;
                end else if (rx_fifo_data == SYNC_BYTE) begin
                    state_d = (state_q == SYNC1) ? SYNC2 : CTRL;
                end else begin
                    // The offending byte is consumed, not re-hunted.
                    sync_err_d = 1'b1;
                    state_d    = SYNC0;
                end
            end
            CTRL: begin
                if (!rx_fifo_enable) begin
                    frame_err_d = 1'b1;
                    state_d     = SYNC0;
                end else begin
                    ctrl_sr_d = ctrl_full[31:0];
                    if (ctrl_cnt_q == 3'(CTRL_BYTES - 1)) begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = ctrl_full[39:33];
                        cmd_ptt_d   = ctrl_full[32];
                        cmd_data_d  = ctrl_full[31:0];
                        state_d     = SAMPLES;
                    end else begin
                        ctrl_cnt_d = ctrl_cnt_q + 3'd1;
                    end
                end
            end
            SAMPLES: begin
                if (!rx_fifo_enable) begin
                    frame_err_d = 1'b1;
                    state_d     = SYNC0;
                end else begin
                    smp_sr_d = smp_full[55:0];
                    if (grp_byte_q == 3'(GROUP_BYTES - 1)) begin
                        sample_valid_d = 1'b1;
                        audio_l_d      = smp_full[63:48];
                        audio_r_d      = smp_full[47:32];
                        tx_i_d         = smp_full[31:16];
                        tx_q_d         = smp_full[15:0];
                        grp_byte_d     = 3'd0;
                        if (grp_cnt_q == 8'(SAMPLES_PER_FRAME - 1)) begin
                            state_d = SYNC0;
                        end else begin
                            grp_cnt_d = grp_cnt_q + 8'd1;
                        end
                    end else begin
                        grp_byte_d = grp_byte_q + 3'd1;
                    end
                end
            end
            default: state_d = SYNC0;
        endcase

        // Every return to hunting starts the next frame from clean counters.
        if (state_d == SYNC0) begin
            ctrl_cnt_d = 3'd0;
            grp_byte_d = 3'd0;
            grp_cnt_d  = 8'd0;
        end
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_q        <= SYNC0;
            ctrl_cnt_q     <= 3'd0;
            grp_byte_q     <= 3'd0;
            grp_cnt_q      <= 8'd0;
            ctrl_sr_q      <= 32'd0;
            smp_sr_q       <= 56'd0;
            cmd_valid_q    <= 1'b0;
            cmd_addr_q     <= 7'd0;
            cmd_ptt_q      <= 1'b0;
            cmd_data_q     <= 32'd0;
            sample_valid_q <= 1'b0;
            audio_l_q      <= 16'd0;
            audio_r_q      <= 16'd0;
            tx_i_q         <= 16'd0;
            tx_q_q         <= 16'd0;
            sync_err_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ctrl_cnt_q     <= ctrl_cnt_d;
            grp_byte_q     <= grp_byte_d;
            grp_cnt_q      <= grp_cnt_d;
            ctrl_sr_q      <= ctrl_sr_d;
            smp_sr_q       <= smp_sr_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_addr_q     <= cmd_addr_d;
            cmd_ptt_q      <= cmd_ptt_d;
            cmd_data_q     <= cmd_data_d;
            sample_valid_q <= sample_valid_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
            tx_i_q         <= tx_i_d;
            tx_q_q         <= tx_q_d;
            sync_err_q     <= sync_err_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_addr     = cmd_addr_q;
    assign cmd_ptt      = cmd_ptt_q;
    assign cmd_data     = cmd_data_q;
    assign sample_valid = sample_valid_q;
    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign tx_i         = tx_i_q;
    assign tx_q         = tx_q_q;
    assign sync_err     = sync_err_q;
    assign frame_err    = frame_err_q;

endmodule

// File: doc/rx_frame_parse.md
Name: rx_frame_parse

Overview:
- Consumes the host-to-radio byte stream that the old-protocol RX receive stage forwards (rx_fifo_data / rx_fifo_enable): 1024 payload bytes per UDP packet, holding two 512-byte USB-style frames.
- Locks to the 3-byte sync, extracts the C0..C4 command words, and assembles the 63 L/R/I/Q sample groups per frame.
- Outputs feed the command register file and the TX IQ / audio FIFOs.

Parameters:
SYNC_BYTE, 8'h7F, sync value; all three sync bytes must match it.
SAMPLES_PER_FRAME, 63, sample groups (8 bytes each) following the control bytes.

Ports:
rx_clk  in  1  byte clock, same domain as the RX receive stage.
rst  in  1  reset, asynchronous, active-high.
rx_fifo_data  in  8  payload byte.
rx_fifo_enable  in  1  byte valid; high contiguously for each packet's payload.
cmd_valid  out  1  one-cycle pulse: new command captured.
cmd_addr  out  7  C0[7:1].
cmd_ptt  out  1  C0[0].
cmd_data  out  32  {C1,C2,C3,C4}, C1 in [31:24].
sample_valid  out  1  one-cycle pulse: new sample group.
audio_l  out  16  left audio, big-endian assembled.
audio_r  out  16  right audio.
tx_i  out  16  TX I.
tx_q  out  16  TX Q.
sync_err  out  1  one-cycle pulse: sync mismatch.
frame_err  out  1  one-cycle pulse: enable dropped mid-frame.

Behaviour:
- Reset (async, any time, including mid-frame): state=SYNC0, byte counters=0, all outputs=0. Held values and data outputs clear.
- A byte is accepted only on a cycle with rx_fifo_enable=1. Cycles with enable=0 inside a frame are a truncation (see below). Cycles with enable=0 in SYNC0 are idle.
- Frame layout (byte index within frame):
  - 0-2: sync.
  - 3-7: C0..C4.
  - 8-511: 63 groups of L_hi,L_lo,R_hi,R_lo,I_hi,I_lo,Q_hi,Q_lo.
- States:
  - SYNC0: accepted byte == SYNC_BYTE -> SYNC1; other accepted bytes are discarded silently (hunt).
  - SYNC1: byte == SYNC_BYTE -> SYNC2, else pulse sync_err, go to SYNC0.
  - SYNC2: byte == SYNC_BYTE -> CTRL, else pulse sync_err, go to SYNC0.
  - Note: the mismatching byte is not re-evaluated as a new SYNC0 candidate.
  - CTRL: 5 bytes shifted into a 40-bit register. On the 5th byte go to SAMPLES.
  - SAMPLES: 8-bit group counter (0..7) and group counter (0..62). After group 62 byte 7, return to SYNC0.
- Command output:
  - cmd_addr, cmd_ptt and cmd_data update and cmd_valid=1 on the cycle after C4 is accepted (1-cycle latency).
  - Values are held until the next command.
  - Every frame with valid sync emits a command; no filtering.
- Sample output:
  - All four words update together, and sample_valid=1, on the cycle after the Q_lo byte is accepted.
  - Values are held otherwise.
  - Partial groups are never emitted.
- Truncation: enable=0 while in SYNC1, SYNC2, CTRL or SAMPLES:
  - pulse frame_err next cycle, go to SYNC0, discard the partial command or group;
  - no cmd_valid or sample_valid for the partial data.
- Back-to-back frames: after the last byte of frame 0, the next accepted byte is evaluated in SYNC0 with no gap required.
- Counters never wrap silently; they are reset on every return to SYNC0.
- sync_err and frame_err are never asserted in the same cycle; sync_err takes precedence by construction.

Decomposition:
- Shared package holds:
  - the state enum {SYNC0,SYNC1,SYNC2,CTRL,SAMPLES};
  - FRAME_BYTES=512, CTRL_BYTES=5, GROUP_BYTES=8;
  - a default SYNC_BYTE constant.
- No sub-module: a single FSM plus shift registers is 150-250 lines.
- The sample assembler stays inline.

Test Plan:
- Two clean frames, C0=8'h03, C1..C4=11 22 33 44; samples L=0001,R=0002,I=1234,Q=8765 per group. Expected:
  - 2 cmd_valid pulses with cmd_addr=7'h01, cmd_ptt=1, cmd_data=32'h11223344;
  - 126 sample_valid pulses, each with exact words and 1-cycle latency;
  - no error pulses.
- Stream starting 00 7F 7F 7E, then a good frame. Expected:
  - byte 00 is discarded silently;
  - one sync_err at 7E;
  - lock on the following frame, with exactly one cmd_valid.
- Enable dropped after byte 100 of a frame. Expected:
  - frame_err one cycle later;
  - no sample_valid for the partial group;
  - the next packet parses normally.
- Async rst asserted mid-SAMPLES. Expected:
  - all outputs are 0 immediately;
  - after release, a clean frame parses correctly.
- 1024-byte packet with no idle between frames. Expected:
  - second sync recognised on the byte right after frame 0 ends;
  - cmd_valid pulses 512 cycles apart.
